// File: rtl/bf16_pkg.sv
// Shared BF16 definitions: opcode encodings, canonical quiet NaN, issuer FSM states.
package bf16_pkg;

  localparam int unsigned BF16_W = 16;

  localparam logic [2:0] OPC_ADD     = 3'b000;
  localparam logic [2:0] OPC_SUB     = 3'b001;
  localparam logic [2:0] OPC_MUL     = 3'b010;
  localparam logic [2:0] OPC_MUL_ALT = 3'b011;
  localparam logic [2:0] OPC_DIV     = 3'b100;

  localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7fc0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_KILL = 2'd2
  } issuer_state_e;

  // Opcodes 000..100 reach the unit; 101..111 complete locally with an error.
  function automatic logic is_legal_opc(input logic [2:0] opc);
    return (opc <= OPC_DIV);
  endfunction

endpackage

// File: rtl/bf16_tag_fifo.sv
// Synchronous ordering FIFO holding {tag, bypass} per in-flight command.
module bf16_tag_fifo #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bf16_op_issuer.sv
// In-order command front end for one BF16Unit: issues legal ops, bypasses illegal
// ones with a NaN/error result, and returns results in command order.
module bf16_op_issuer
  import bf16_pkg::*;
#(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned MAX_OUT   = 4,
  parameter logic [15:0] NAN_VALUE = BF16_QNAN,
  localparam int unsigned CNT_W    = $clog2(MAX_OUT) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opc,
  input  logic             cmd_is_sqrt,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             kill,
  output logic [2:0]       u_opc,
  output logic [15:0]      u_a,
  output logic [15:0]      u_b,
  output logic             u_is_sqrt,
  output logic             u_in_valid,
  input  logic             u_in_ready,
  output logic             u_kill,
  input  logic             u_out_valid,
  output logic             u_out_ready,
  input  logic [15:0]      u_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_y,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic [CNT_W-1:0] outstanding
);

  issuer_state_e state_q, state_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [TAG_W:0]   fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             head_byp;
  logic [TAG_W-1:0] head_tag;

  logic cmd_legal, active, accept, accept_legal;
  logic res_load_ok, pop_bypass, pop_unit;

  logic [2:0]       u_opc_q, u_opc_d;
  logic [15:0]      u_a_q, u_a_d, u_b_q, u_b_d;
  logic             u_sqrt_q, u_sqrt_d;
  logic             u_in_valid_q, u_in_valid_d;

  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_y_q, res_y_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_err_q, res_err_d;

  // Handshake qualification; a pending kill blocks every transfer this cycle.
  assign cmd_legal    = is_legal_opc(cmd_opc);
  assign active       = (state_q != ST_KILL) && !kill;
  assign cmd_ready    = reset && active && !fifo_full &&
                        (!cmd_legal || u_in_ready || !u_in_valid_q);
  assign accept       = cmd_valid && cmd_ready;
  assign accept_legal = accept && cmd_legal;

  assign {head_tag, head_byp} = fifo_rdata;
  assign fifo_wdata           = {cmd_tag, !cmd_legal};

  assign res_load_ok = !res_valid_q || res_ready;
  assign u_out_ready = active && !fifo_empty && !head_byp && res_load_ok;
  assign pop_bypass  = active && !fifo_empty && head_byp && res_load_ok;
  assign pop_unit    = u_out_ready && u_out_valid;
  assign fifo_pop    = pop_bypass || pop_unit;

  bf16_tag_fifo #(
    .W     (TAG_W + 1),
    .DEPTH (MAX_OUT)
  ) u_order_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (kill),
    .push_i  (accept),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next state: kill dominates, KILL lasts one cycle, RUN drains back to IDLE.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = ST_KILL;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) state_d = ST_RUN;
        ST_RUN: begin
          if (!accept && (fifo_empty || (fifo_pop && fifo_count == CNT_W'(1))))
            state_d = ST_IDLE;
        end
        ST_KILL: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Issue stage: operands registered on accept, held until the unit takes them.
  always_comb begin
    u_opc_d      = u_opc_q;
    u_a_d        = u_a_q;
    u_b_d        = u_b_q;
    u_sqrt_d     = u_sqrt_q;
    u_in_valid_d = u_in_valid_q;
    if (u_in_valid_q && u_in_ready) u_in_valid_d = 1'b0;
    if (accept_legal) begin
      u_opc_d      = cmd_opc;
      u_a_d        = cmd_a;
      u_b_d        = cmd_b;
      u_sqrt_d     = cmd_is_sqrt;
      u_in_valid_d = 1'b1;
    end
    if (kill) u_in_valid_d = 1'b0;
  end

  // Result stage: one-entry register filled from the FIFO head in order.
  always_comb begin
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    if (pop_bypass) begin
      res_valid_d = 1'b1;
      res_y_d     = NAN_VALUE;
      res_tag_d   = head_tag;
      res_err_d   = 1'b1;
    end else if (pop_unit) begin
      res_valid_d = 1'b1;
      res_y_d     = u_y;
      res_tag_d   = head_tag;
      res_err_d   = 1'b0;
    end
    if (kill) res_valid_d = 1'b0;
  end

  // State, issue and result registers; reset returns every output to zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      u_opc_q      <= '0;
      u_a_q        <= '0;
      u_b_q        <= '0;
      u_sqrt_q     <= 1'b0;
      u_in_valid_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_y_q      <= '0;
      res_tag_q    <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      u_opc_q      <= u_opc_d;
      u_a_q        <= u_a_d;
      u_b_q        <= u_b_d;
      u_sqrt_q     <= u_sqrt_d;
      u_in_valid_q <= u_in_valid_d;
      res_valid_q  <= res_valid_d;
      res_y_q      <= res_y_d;
      res_tag_q    <= res_tag_d;
      res_err_q    <= res_err_d;
    end
  end

  assign u_opc       = u_opc_q;
  assign u_a         = u_a_q;
  assign u_b         = u_b_q;
  assign u_is_sqrt   = u_sqrt_q;
  assign u_in_valid  = u_in_valid_q;
  assign u_kill      = (state_q == ST_KILL);
  assign res_valid   = res_valid_q;
  assign res_y       = res_y_q;
  assign res_tag     = res_tag_q;
  assign res_err     = res_err_q;
  assign outstanding = fifo_count;

  // A unit result with nothing outstanding means the unit and issuer disagree.
  assert property (@(posedge clock) disable iff (!reset)
                   (u_out_valid && state_q != ST_KILL) |-> !fifo_empty);

endmodule

// File: tb/tb_bf16_op_issuer.sv
// Directed bench for bf16_op_issuer with a small behavioural BF16Unit stand-in.
module tb_bf16_op_issuer;

  localparam int TAG_W   = 4;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_opc = '0;
  logic             cmd_is_sqrt = 1'b0;
  logic [15:0]      cmd_a = '0, cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic             kill = 1'b0;
  logic [2:0]       u_opc;
  logic [15:0]      u_a, u_b;
  logic             u_is_sqrt, u_in_valid;
  logic             u_in_ready = 1'b1;
  logic             u_kill;
  logic             u_out_valid = 1'b0;
  logic             u_out_ready;
  logic [15:0]      u_y = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [15:0]      res_y;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic [CNT_W-1:0] outstanding;

  typedef struct packed {
    logic [15:0]      y;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  res_t        got[$];
  logic [15:0] uq[$];
  logic        out_en = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_issued = 0;

  bf16_op_issuer #(.TAG_W(TAG_W), .MAX_OUT(MAX_OUT), .NAN_VALUE(16'h7fc0)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opc(cmd_opc),
    .cmd_is_sqrt(cmd_is_sqrt), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .kill(kill),
    .u_opc(u_opc), .u_a(u_a), .u_b(u_b), .u_is_sqrt(u_is_sqrt),
    .u_in_valid(u_in_valid), .u_in_ready(u_in_ready), .u_kill(u_kill),
    .u_out_valid(u_out_valid), .u_out_ready(u_out_ready), .u_y(u_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_tag(res_tag), .res_err(res_err), .outstanding(outstanding)
  );

  always #5 clock = ~clock;

  // Hand-computed BF16 results for a=25.5 (41cc), b=21.5 (41ac).
  function automatic logic [15:0] model_y(input logic [2:0] opc, input logic sq,
                                           input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h41cc && b == 16'h41ac) begin
      case (opc)
        3'd0:    return 16'h423c;
        3'd1:    return 16'h4080;
        3'd2:    return 16'h4409;
        3'd3:    return 16'h4409;
        3'd4:    return sq ? 16'h40a2 : 16'h3f98;
        default: return 16'hbad0;
      endcase
    end
    return 16'hbad0;
  endfunction

  // Unit stand-in: accepts issues, queues results, flushed by u_kill or reset.
  initial forever begin
    @(posedge clock);
    if (!reset || u_kill) begin
      uq.delete();
    end else begin
      if (u_out_valid && u_out_ready && uq.size() > 0) void'(uq.pop_front());
      if (u_in_valid && u_in_ready) begin
        uq.push_back(model_y(u_opc, u_is_sqrt, u_a, u_b));
        n_issued++;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (out_en && uq.size() > 0) begin
      u_out_valid = 1'b1;
      u_y         = uq[0];
    end else begin
      u_out_valid = 1'b0;
      u_y         = '0;
    end
  end

  // Result collector.
  initial forever begin
    res_t r;
    @(posedge clock);
    if (reset && res_valid && res_ready) begin
      r = {res_y, res_tag, res_err};
      got.push_back(r);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [2:0] opc, input logic sq, input logic [15:0] a,
                          input logic [15:0] b, input logic [TAG_W-1:0] tag);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_opc = opc; cmd_is_sqrt = sq; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clock);
      if (cmd_ready) ok = 1;
    end
    #1 cmd_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL send_cmd tag=%0d not accepted, got ready=0 want 1", tag); end
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 200 && got.size() < n; c++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain_idle();
    for (int c = 0; c < 200 && (outstanding != 0 || res_valid || u_in_valid); c++) begin
      @(posedge clock); #1;
    end
    got.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got=%b want 0", res_valid); end
    n_checks++; if (res_y !== 16'h0) begin n_fail++; $display("FAIL rst_res_y got=%h want 0000", res_y); end
    n_checks++; if (u_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_u_in_valid got=%b want 0", u_in_valid); end
    n_checks++; if (u_kill !== 1'b0) begin n_fail++; $display("FAIL rst_u_kill got=%b want 0", u_kill); end
    n_checks++; if (u_out_ready !== 1'b0) begin n_fail++; $display("FAIL rst_u_out_ready got=%b want 0", u_out_ready); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding got=%0d want 0", outstanding); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got=%b want 0", cmd_ready); end
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready got=%b want 1", cmd_ready); end
  endtask

  task automatic test_basic_ops();
    logic [15:0] ey[4] = '{16'h423c, 16'h4080, 16'h4409, 16'h4409};
    drain_idle();
    u_in_ready = 1'b1; out_en = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_cmd(3'(i), 1'b0, 16'h41cc, 16'h41ac, 4'(i + 1));
    wait_results(4);
    n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL basic_count got=%0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++; if (got[i].y !== ey[i]) begin n_fail++; $display("FAIL basic_y[%0d] got=%h want %h", i, got[i].y, ey[i]); end
      n_checks++; if (got[i].tag !== 4'(i + 1)) begin n_fail++; $display("FAIL basic_tag[%0d] got=%0d want %0d", i, got[i].tag, i + 1); end
      n_checks++; if (got[i].err !== 1'b0) begin n_fail++; $display("FAIL basic_err[%0d] got=%b want 0", i, got[i].err); end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] ey[3] = '{16'h423c, 16'h7fc0, 16'h4080};
    logic        ee[3] = '{1'b0, 1'b1, 1'b0};
    int n0;
    drain_idle();
    n0 = n_issued;
    send_cmd(3'd0, 1'b0, 16'h41cc, 16'h41ac, 4'd0);
    send_cmd(3'd7, 1'b0, 16'h41cc, 16'h41ac, 4'd1);
    send_cmd(3'd1, 1'b0, 16'h41cc, 16'h41ac, 4'd2);
    wait_results(3);
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bypass_count got=%0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++; if (got[i].y !== ey[i]) begin n_fail++; $display("FAIL bypass_y[%0d] got=%h want %h", i, got[i].y, ey[i]); end
      n_checks++; if (got[i].tag !== 4'(i)) begin n_fail++; $display("FAIL bypass_tag[%0d] got=%0d want %0d", i, got[i].tag, i); end
      n_checks++; if (got[i].err !== ee[i]) begin n_fail++; $display("FAIL bypass_err[%0d] got=%b want %b", i, got[i].err, ee[i]); end
    end
    n_checks++; if (n_issued - n0 != 2) begin n_fail++; $display("FAIL bypass_issues got=%0d want 2", n_issued - n0); end
  endtask

  task automatic test_backpressure();
    logic [2:0]  op[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [15:0] ey[6] = '{16'h423c, 16'h4080, 16'h4409, 16'h4409, 16'h3f98, 16'h423c};
    int  idx = 0;
    bit  acc;
    drain_idle();
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_opc = op[0]; cmd_is_sqrt = 1'b0; cmd_a = 16'h41cc; cmd_b = 16'h41ac; cmd_tag = 4'd8;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); acc = cmd_valid && cmd_ready; #1;
      if (acc) begin
        idx++;
        if (idx < 6) begin cmd_opc = op[idx]; cmd_tag = 4'(8 + idx); end
        else cmd_valid = 1'b0;
      end
    end
    n_checks++; if (idx != 5) begin n_fail++; $display("FAIL bp_accepted got=%0d want 5", idx); end
    n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL bp_outstanding got=%0d want 4", outstanding); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready got=%b want 0", cmd_ready); end
    repeat (3) begin
      @(posedge clock); #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_y !== 16'h423c || res_tag !== 4'd8) begin
        n_fail++; $display("FAIL bp_hold got v=%b y=%h t=%0d want v=1 y=423c t=8", res_valid, res_y, res_tag);
      end
    end
    res_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      @(posedge clock); acc = cmd_valid && cmd_ready; #1;
      if (acc) begin idx++; cmd_valid = 1'b0; end
    end
    cmd_valid = 1'b0;
    wait_results(6);
    n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_count got=%0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_checks++;
      if (got[i].y !== ey[i] || got[i].tag !== 4'(8 + i) || got[i].err !== 1'b0) begin
        n_fail++; $display("FAIL bp_res[%0d] got y=%h t=%0d e=%b want y=%h t=%0d e=0", i, got[i].y, got[i].tag, got[i].err, ey[i], 8 + i);
      end
    end
  endtask

  task automatic test_issue_stall();
    int n0;
    drain_idle();
    u_in_ready = 1'b0;
    send_cmd(3'd2, 1'b0, 16'h41cc, 16'h41ac, 4'd5);
    n0 = n_issued;
    n_checks++; if (u_in_valid !== 1'b1) begin n_fail++; $display("FAIL stall_latency u_in_valid got=%b want 1", u_in_valid); end
    repeat (5) begin
      @(posedge clock); #1;
      n_checks++;
      if (u_in_valid !== 1'b1 || u_opc !== 3'd2 || u_a !== 16'h41cc || u_b !== 16'h41ac) begin
        n_fail++; $display("FAIL stall_hold got v=%b opc=%0d a=%h b=%h want v=1 opc=2 a=41cc b=41ac", u_in_valid, u_opc, u_a, u_b);
      end
    end
    u_in_ready = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (n_issued - n0 != 1) begin n_fail++; $display("FAIL stall_issue got=%0d want 1", n_issued - n0); end
    n_checks++; if (u_in_valid !== 1'b0) begin n_fail++; $display("FAIL stall_clear got=%b want 0", u_in_valid); end
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (n_issued - n0 != 1) begin n_fail++; $display("FAIL stall_dup got=%0d want 1", n_issued - n0); end
    wait_results(1);
    n_checks++;
    if (got.size() < 1 || got[0].y !== 16'h4409 || got[0].tag !== 4'd5) begin
      n_fail++; $display("FAIL stall_res got n=%0d want y=4409 t=5", got.size());
    end
  endtask

  task automatic test_kill();
    drain_idle();
    out_en = 1'b0; u_in_ready = 1'b1; res_ready = 1'b1;
    send_cmd(3'd0, 1'b0, 16'h41cc, 16'h41ac, 4'd1);
    send_cmd(3'd1, 1'b0, 16'h41cc, 16'h41ac, 4'd2);
    send_cmd(3'd2, 1'b0, 16'h41cc, 16'h41ac, 4'd3);
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL kill_pre_outstanding got=%0d want 3", outstanding); end
    kill = 1'b1;
    @(posedge clock); #1;
    kill = 1'b0;
    n_checks++; if (u_kill !== 1'b1) begin n_fail++; $display("FAIL kill_u_kill got=%b want 1", u_kill); end
    n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL kill_outstanding got=%0d want 0", outstanding); end
    n_checks++; if (u_in_valid !== 1'b0) begin n_fail++; $display("FAIL kill_u_in_valid got=%b want 0", u_in_valid); end
    n_checks++; if (cmd_ready !== 1'b0 || u_out_ready !== 1'b0) begin n_fail++; $display("FAIL kill_ready got cmd=%b out=%b want 0 0", cmd_ready, u_out_ready); end
    @(posedge clock); #1;
    n_checks++; if (u_kill !== 1'b0) begin n_fail++; $display("FAIL kill_one_cycle got=%b want 0", u_kill); end
    out_en = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL kill_no_res got=%0d want 0", got.size()); end
    send_cmd(3'd1, 1'b0, 16'h41cc, 16'h41ac, 4'd7);
    wait_results(1);
    n_checks++;
    if (got.size() != 1 || got[0].y !== 16'h4080 || got[0].tag !== 4'd7 || got[0].err !== 1'b0) begin
      n_fail++; $display("FAIL kill_after got n=%0d want one y=4080 t=7 e=0", got.size());
    end
  endtask

  task automatic test_reset_mid();
    drain_idle();
    out_en = 1'b1; u_in_ready = 1'b1; res_ready = 1'b0;
    send_cmd(3'd0, 1'b0, 16'h41cc, 16'h41ac, 4'd1);
    send_cmd(3'd1, 1'b0, 16'h41cc, 16'h41ac, 4'd2);
    repeat (4) @(posedge clock);
    #1;
    n_checks++; if (res_valid !== 1'b1 || outstanding !== 3'd1) begin n_fail++; $display("FAIL rmid_pre got v=%b occ=%0d want 1 1", res_valid, outstanding); end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n_checks++; if (res_valid !== 1'b0 || res_y !== 16'h0 || res_tag !== 4'd0 || res_err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_res got v=%b y=%h t=%0d e=%b want all 0", res_valid, res_y, res_tag, res_err);
    end
    n_checks++; if (u_in_valid !== 1'b0 || u_a !== 16'h0 || u_opc !== 3'd0 || u_kill !== 1'b0) begin
      n_fail++; $display("FAIL rmid_issue got v=%b a=%h opc=%0d k=%b want all 0", u_in_valid, u_a, u_opc, u_kill);
    end
    n_checks++; if (outstanding !== 3'd0 || u_out_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_fifo got occ=%0d ordy=%b want 0 0", outstanding, u_out_ready); end
    res_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL rmid_no_res got=%0d want 0", got.size()); end
    send_cmd(3'd2, 1'b0, 16'h41cc, 16'h41ac, 4'd9);
    wait_results(1);
    n_checks++;
    if (got.size() != 1 || got[0].y !== 16'h4409 || got[0].tag !== 4'd9) begin
      n_fail++; $display("FAIL rmid_after got n=%0d want one y=4409 t=9", got.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_bypass();
    test_backpressure();
    test_issue_stall();
    test_kill();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
